// File: rtl/arith_width_serializer_if.sv
// -----------------------------------------------------------------------------
// arith_width_serializer_if
//   Bundles the operand-side and beat-side handshakes of the width serializer.
//
//   Parameters:
//     IN_WIDTH   width of the wide operand (a_data)
//     OUT_WIDTH  width of one output beat (result_data)
//
//   Signals:
//     a_valid       operand valid              (producer -> serializer)
//     a_ready       serializer takes operand   (serializer -> producer)
//     a_data        wide operand               (producer -> serializer)
//     result_valid  beat valid                 (serializer -> consumer)
//     result_ready  consumer takes beat        (consumer -> serializer)
//     result_data   current beat, LS slice first
//     result_last   final beat of the operand
//
//   Modports:
//     slave   the serializer itself
//     master  the environment driving operands and consuming beats
// -----------------------------------------------------------------------------
interface arith_width_serializer_if #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
);
   logic                 a_valid;
   logic                 a_ready;
   logic [IN_WIDTH-1:0]  a_data;
   logic                 result_valid;
   logic                 result_ready;
   logic [OUT_WIDTH-1:0] result_data;
   logic                 result_last;

   modport slave (
      input  a_valid,
      input  a_data,
      input  result_ready,
      output a_ready,
      output result_valid,
      output result_data,
      output result_last
   );

   modport master (
      output a_valid,
      output a_data,
      output result_ready,
      input  a_ready,
      input  result_valid,
      input  result_data,
      input  result_last
   );
endinterface

// File: rtl/arith_width_serializer.sv
// -----------------------------------------------------------------------------
// arith_width_serializer
//   Accepts one IN_WIDTH-bit operand and emits it as NUM_BEATS consecutive
//   OUT_WIDTH-bit beats, least-significant slice first. The final beat of one
//   operand and the capture of the next can share a cycle, so a continuously
//   fed serializer produces one operand every NUM_BEATS cycles with no bubble.
//
//   Parameters:
//     IN_WIDTH   operand width (default 64)
//     OUT_WIDTH  beat width (default 16); OUT_WIDTH > IN_WIDTH is rejected
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset
//     bus   arith_width_serializer_if.slave (a_* operand side, result_* beat side)
//
//   Configuration macro:
//     ARITH_WIDTH_SERIALIZER_SIGN_FILL_EN
//       defined   : unused upper bits of the final beat copy the operand MSB
//       undefined : unused upper bits of the final beat are zero
// -----------------------------------------------------------------------------
module arith_width_serializer #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
) (
   input logic                     clk,
   input logic                     rst,
   arith_width_serializer_if.slave bus
);

   localparam int NUM_BEATS    = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int PADDED_WIDTH = NUM_BEATS * OUT_WIDTH;
   localparam int FILL_BITS    = PADDED_WIDTH - IN_WIDTH;
   localparam int CNT_WIDTH    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_BEATS - 1);

   generate
      if (OUT_WIDTH > IN_WIDTH) begin : g_width_check
         $error("arith_width_serializer: OUT_WIDTH (%0d) exceeds IN_WIDTH (%0d)",
                OUT_WIDTH, IN_WIDTH);
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                  state_reg, state_next;
   logic [PADDED_WIDTH-1:0] shift_reg, shift_next;
   logic [CNT_WIDTH-1:0]    count_reg, count_next;

   logic                    fill_bit;
   logic [PADDED_WIDTH-1:0] captured;
   logic                    last_beat;
   logic                    a_ready;
   logic                    result_valid;

   // ------------------------------------------------------------------
   // Operand as loaded into the shift register: the operand itself in the
   // low bits, fill bits above it so the final beat is fully defined.
   // ------------------------------------------------------------------
`ifdef ARITH_WIDTH_SERIALIZER_SIGN_FILL_EN
   assign fill_bit = bus.a_data[IN_WIDTH-1];
`else
   assign fill_bit = 1'b0;
`endif

   assign captured[IN_WIDTH-1:0] = bus.a_data;

   generate
      for (genvar gi = 0; gi < FILL_BITS; gi++) begin : g_fill
         assign captured[IN_WIDTH+gi] = fill_bit;
      end
   endgenerate

   // last_beat is qualified by SEND so result_last stays low in IDLE.
   assign last_beat = (state_reg == SEND) && (count_reg == LAST_BEAT);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         count_reg <= count_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and handshake logic.
   // result_valid comes only from state_reg; a_ready is the single path
   // that looks at an input (result_ready) in the same cycle, which is what
   // lets the last beat and the next capture overlap.
   // ------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      count_next   = count_reg;
      a_ready      = 1'b0;
      result_valid = 1'b0;

      unique case (state_reg)
         IDLE: begin
            a_ready = 1'b1;
            if (bus.a_valid) begin
               shift_next = captured;
               count_next = '0;
               state_next = SEND;
            end
         end

         SEND: begin
            result_valid = 1'b1;
            if (bus.result_ready) begin
               if (last_beat) begin
                  a_ready = 1'b1;
                  if (bus.a_valid) begin
                     // Back-to-back: reload without passing through IDLE.
                     shift_next = captured;
                     count_next = '0;
                     state_next = SEND;
                  end else begin
                     // Clear so an idle serializer presents zero data.
                     shift_next = '0;
                     count_next = '0;
                     state_next = IDLE;
                  end
               end else begin
                  shift_next = shift_reg >> OUT_WIDTH;
                  count_next = count_reg + CNT_WIDTH'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.a_ready      = a_ready;
   assign bus.result_valid = result_valid;
   assign bus.result_data  = shift_reg[OUT_WIDTH-1:0];
   assign bus.result_last  = last_beat;

endmodule

// File: doc/arith_width_serializer.md
ARITH_WIDTH_SERIALIZER -- requirements
Module: arith_width_serializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64, giving the width of the wide input operand.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, giving the width of each output beat.
REQ-003 SHALL derive localparam NUM_BEATS = ceil(IN_WIDTH/OUT_WIDTH); OUT_WIDTH > IN_WIDTH SHALL be an elaboration error.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a_valid  input  1  input operand valid.
REQ-007 a_ready  output  1  block can accept an operand.
REQ-008 a_data  input  IN_WIDTH  wide operand.
REQ-009 result_valid  output  1  output beat valid.
REQ-010 result_ready  input  1  downstream accepts beat.
REQ-011 result_data  output  OUT_WIDTH  current beat, least-significant slice first.
REQ-012 result_last  output  1  high on the final beat of an operand.

Function
REQ-013 SHALL implement two states: IDLE (no operand held) and SEND (operand held, beats pending).
REQ-014 IDLE SHALL drive a_ready=1, result_valid=0; a_valid&&a_ready SHALL capture a_data into a shift register, clear beat counter to 0, and enter SEND.
REQ-015 SEND SHALL drive result_valid=1, result_data = low OUT_WIDTH bits of shift register, result_last = (counter == NUM_BEATS-1).
REQ-016 In SEND, result_valid&&result_ready on a non-last beat SHALL shift the register right by OUT_WIDTH and increment the counter.
REQ-017 In SEND, acceptance of the last beat SHALL return to IDLE, unless a_valid is also high, in which case the new operand SHALL be captured and SEND re-entered with counter 0 (no bubble).
REQ-018 a_ready SHALL equal IDLE || (SEND && result_last && result_ready); this is the only combinational input-to-output path.
REQ-019 First beat SHALL be valid the cycle after operand acceptance (latency 1); sustained throughput SHALL be one operand per NUM_BEATS cycles.
REQ-020 While result_valid && !result_ready, result_data, result_last and the counter SHALL remain stable.
REQ-021 Upper (NUM_BEATS*OUT_WIDTH - IN_WIDTH) bits of the final beat, when IN_WIDTH is not a multiple of OUT_WIDTH, SHALL be filled per REQ-026.
REQ-022 NUM_BEATS==1 SHALL behave as a one-entry register stage with result_last permanently high while valid.
REQ-023 result_valid SHALL never depend combinationally on result_ready or a_valid.

Reset
REQ-024 rst SHALL force IDLE, counter 0, shift register 0, result_valid=0, result_last=0, result_data=0, a_ready=1 on the following cycle, discarding any partially sent operand.
REQ-025 rst SHALL take priority over any concurrent handshake in the same cycle.

Configuration
REQ-026 Macro ARITH_WIDTH_SERIALIZER_SIGN_FILL_EN: defined -> final-beat fill bits SHALL replicate a_data[IN_WIDTH-1] captured at acceptance; undefined -> fill bits SHALL be 0.

Verification
REQ-027 IN=64, OUT=16, a_data=0x1122334455667788, result_ready=1 -> beats 0x7788,0x5566,0x3344,0x1122 on consecutive cycles, result_last only on 0x1122.
REQ-028 Same operand, result_ready low 3 cycles on beat 2 -> 0x5566 held stable those cycles, a_ready=0, sequence otherwise unchanged.
REQ-029 Two operands back-to-back with a_valid held high -> 8 consecutive valid beats, no idle cycle, second operand accepted in cycle of first's last beat.
REQ-030 IN=40, OUT=16, a_data=0x8012345678 -> 0x5678,0x1234, then 0xFF80 with SIGN_FILL_EN, 0x0080 without.
REQ-031 rst asserted after beat 2 of 4 -> next cycle result_valid=0, a_ready=1; next operand restarts at beat 0.
REQ-032 IN=OUT=32, a_data=0xDEADBEEF -> single beat 0xDEADBEEF, result_last=1, latency 1 cycle.
